// File: rtl/pipo_rr_arbiter_if.sv
// Bundle of request, data and grant/register signals shared by the
// round-robin PIPO arbiter and the requesters that drive it.
interface pipo_rr_arbiter_if #(
  parameter int WIDTH = 4
);
  logic [3:0]       req;
  logic [WIDTH-1:0] din0;
  logic [WIDTH-1:0] din1;
  logic [WIDTH-1:0] din2;
  logic [WIDTH-1:0] din3;
  logic [3:0]       gnt;
  logic [1:0]       owner;
  logic [WIDTH-1:0] q;
  logic             load_pulse;
  logic             q_valid;

  modport master (
    output req, din0, din1, din2, din3,
    input  gnt, owner, q, load_pulse, q_valid
  );

  modport slave (
    input  req, din0, din1, din2, din3,
    output gnt, owner, q, load_pulse, q_valid
  );
endinterface

// File: rtl/pipo_rr_arbiter.sv
// Four-way round-robin arbiter that hands a shared parallel register to one
// requester at a time: grant, load the winner's data once, then hold.
module pipo_rr_arbiter #(
  parameter int WIDTH    = 4,
  parameter int HOLD_CYC = 2
) (
  input  logic               clk,
  input  logic               clear,
  pipo_rr_arbiter_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYC - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       last_q, last_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             pulse_q, pulse_d;
  logic             valid_q, valid_d;
  logic [3:0]       cnt_q, cnt_d;

  logic             win_found;
  logic [1:0]       win_idx;
  logic [1:0]       scan_idx;
  logic [WIDTH-1:0] din_sel;

  // Scan starts just past the previous owner, so it is checked last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    scan_idx  = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      scan_idx = last_q + 2'(k);
      if (!win_found && bus.req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    case (owner_q)
      2'd0:    din_sel = bus.din0;
      2'd1:    din_sel = bus.din1;
      2'd2:    din_sel = bus.din2;
      default: din_sel = bus.din3;
    endcase
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    data_d  = data_q;
    pulse_d = 1'b0;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          gnt_d   = 4'b0001 << win_idx;
          owner_d = win_idx;
          last_d  = win_idx;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        data_d  = din_sel;
        pulse_d = 1'b1;
        valid_d = 1'b1;
        cnt_d   = 4'd0;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == HOLD_LAST) begin
          gnt_d   = 4'b0000;
          state_d = S_IDLE;
        end
      end
      default: begin
        gnt_d   = 4'b0000;
        state_d = S_IDLE;
      end
    endcase
  end

  // last_q resets to 3 so requester 0 is first in line after clear.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= S_IDLE;
      gnt_q   <= 4'b0000;
      owner_q <= 2'd0;
      last_q  <= 2'd3;
      data_q  <= '0;
      pulse_q <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      data_q  <= data_d;
      pulse_q <= pulse_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.owner      = owner_q;
  assign bus.q          = data_q;
  assign bus.load_pulse = pulse_q;
  assign bus.q_valid    = valid_q;

endmodule

// File: tb/tb_pipo_rr_arbiter.sv
// Bench for pipo_rr_arbiter: two builds (hold 2 and hold 1) share stimulus and
// are checked every cycle against a grant-countdown model plus literal vectors.
module tb_pipo_rr_arbiter;

  logic       clk;
  logic       clear;
  logic [3:0] req;
  logic [3:0] din_a [4];

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  pipo_rr_arbiter_if #(.WIDTH(4)) bus0 ();
  pipo_rr_arbiter_if #(.WIDTH(4)) bus1 ();

  assign bus0.req  = req;
  assign bus0.din0 = din_a[0];
  assign bus0.din1 = din_a[1];
  assign bus0.din2 = din_a[2];
  assign bus0.din3 = din_a[3];
  assign bus1.req  = req;
  assign bus1.din0 = din_a[0];
  assign bus1.din1 = din_a[1];
  assign bus1.din2 = din_a[2];
  assign bus1.din3 = din_a[3];

  pipo_rr_arbiter #(.WIDTH(4), .HOLD_CYC(2)) dut0 (.clk(clk), .clear(clear), .bus(bus0));
  pipo_rr_arbiter #(.WIDTH(4), .HOLD_CYC(1)) dut1 (.clk(clk), .clear(clear), .bus(bus1));

  logic [3:0] gnt_o   [2];
  logic [1:0] owner_o [2];
  logic [3:0] q_o     [2];
  logic       pulse_o [2];
  logic       valid_o [2];

  assign gnt_o[0]   = bus0.gnt;
  assign owner_o[0] = bus0.owner;
  assign q_o[0]     = bus0.q;
  assign pulse_o[0] = bus0.load_pulse;
  assign valid_o[0] = bus0.q_valid;
  assign gnt_o[1]   = bus1.gnt;
  assign owner_o[1] = bus1.owner;
  assign q_o[1]     = bus1.q;
  assign pulse_o[1] = bus1.load_pulse;
  assign valid_o[1] = bus1.q_valid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a grant lasts 1+hold cycles; the edge after it rises loads q.
  int         hold_of [2] = '{2, 1};
  int         left    [2];
  int         age     [2];
  int         m_owner [2];
  int         m_last  [2];
  logic [3:0] m_q     [2];
  bit         m_valid [2];
  bit         m_pulse [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (clear) begin
        left[k] = 0; age[k] = 0; m_owner[k] = 0; m_last[k] = 3;
        m_q[k] = 4'h0; m_valid[k] = 0; m_pulse[k] = 0;
      end else if (left[k] == 0) begin
        m_pulse[k] = 0;
        for (int j = 1; j <= 4; j++) begin
          int idx;
          idx = (m_last[k] + j) % 4;
          if (left[k] == 0 && req[idx] == 1'b1) begin
            m_owner[k] = idx;
            m_last[k]  = idx;
            left[k]    = 1 + hold_of[k];
            age[k]     = 0;
          end
        end
      end else begin
        age[k]     = age[k] + 1;
        m_pulse[k] = (age[k] == 1);
        if (age[k] == 1) begin
          m_q[k]     = din_a[m_owner[k]];
          m_valid[k] = 1;
        end
        left[k] = left[k] - 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        int eg;
        eg = (left[k] > 0) ? (1 << m_owner[k]) : 0;
        chk($sformatf("model_gnt%0d", k), int'(gnt_o[k]), eg);
        chk($sformatf("model_owner%0d", k), int'(owner_o[k]), m_owner[k]);
        chk($sformatf("model_q%0d", k), int'(q_o[k]), int'(m_q[k]));
        chk($sformatf("model_pulse%0d", k), int'(pulse_o[k]), int'(m_pulse[k]));
        chk($sformatf("model_valid%0d", k), int'(valid_o[k]), int'(m_valid[k]));
        chk($sformatf("onehot%0d", k), int'($countones(gnt_o[k]) <= 1), 1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  int          gorder [$];
  int          qseq   [$];
  logic [3:0]  prev_g;
  int          exp_order [5] = '{0, 1, 2, 3, 0};
  int          exp_q     [5] = '{1, 2, 3, 4, 1};

  initial begin
    clear = 1'b1;
    req   = 4'h0;
    for (int i = 0; i < 4; i++) din_a[i] = 4'h0;
    step();
    chk_en = 1;
    step();
    chk("rst_gnt", int'(gnt_o[0]), 0);
    chk("rst_owner", int'(owner_o[0]), 0);
    chk("rst_q", int'(q_o[0]), 0);
    chk("rst_pulse", int'(pulse_o[0]), 0);
    chk("rst_valid", int'(valid_o[0]), 0);

    // Single requester 2 right after clear.
    clear = 1'b0; req = 4'b0100; din_a[2] = 4'hA;
    step();
    chk("t30_gnt_e0", int'(gnt_o[0]), 4'b0100);
    chk("t30_owner", int'(owner_o[0]), 2);
    chk("t30_q_before", int'(q_o[0]), 0);
    req = 4'b0000;
    step();
    chk("t30_q_e1", int'(q_o[0]), 4'hA);
    chk("t30_pulse_e1", int'(pulse_o[0]), 1);
    chk("t30_valid_e1", int'(valid_o[0]), 1);
    chk("t30_gnt_e1", int'(gnt_o[0]), 4'b0100);
    chk("t35_h1_gnt_e1", int'(gnt_o[1]), 4'b0100);
    step();
    chk("t30_gnt_e2", int'(gnt_o[0]), 4'b0100);
    chk("t30_pulse_e2", int'(pulse_o[0]), 0);
    chk("t35_h1_gnt_e2", int'(gnt_o[1]), 0);
    step();
    chk("t30_gnt_e3", int'(gnt_o[0]), 0);
    chk("t30_valid_e3", int'(valid_o[0]), 1);
    step();

    // All four requesting continuously: strict rotation from 0.
    clear = 1'b1;
    step();
    clear = 1'b0; req = 4'b1111;
    for (int i = 0; i < 4; i++) din_a[i] = 4'(i + 1);
    prev_g = gnt_o[0];
    for (int c = 0; c < 22; c++) begin
      step();
      if (prev_g == 4'h0 && gnt_o[0] != 4'h0) gorder.push_back(int'(owner_o[0]));
      if (pulse_o[0]) qseq.push_back(int'(q_o[0]));
      prev_g = gnt_o[0];
    end
    chk("t31_ngrants", int'(gorder.size() >= 5 && qseq.size() >= 5), 1);
    if (gorder.size() >= 5 && qseq.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("t31_order%0d", i), gorder[i], exp_order[i]);
        chk($sformatf("t31_q%0d", i), qseq[i], exp_q[i]);
      end
    end
    req = 4'b0000;
    for (int c = 0; c < 5; c++) step();

    // Data and req changes during HOLD are ignored.
    clear = 1'b1;
    step();
    clear = 1'b0; req = 4'b0010; din_a[1] = 4'h5;
    step();
    chk("t32_gnt_e0", int'(gnt_o[0]), 4'b0010);
    step();
    chk("t32_q_e1", int'(q_o[0]), 4'h5);
    din_a[1] = 4'hF; req = 4'b0000;
    step();
    chk("t32_gnt_e2", int'(gnt_o[0]), 4'b0010);
    chk("t32_q_e2", int'(q_o[0]), 4'h5);
    step();
    chk("t32_gnt_e3", int'(gnt_o[0]), 0);
    chk("t32_q_e3", int'(q_o[0]), 4'h5);
    step();

    // Clear during LOAD aborts the grant and the load.
    req = 4'b0001; din_a[0] = 4'h7;
    step();
    chk("t33_gnt_e0", int'(gnt_o[0]), 4'b0001);
    clear = 1'b1;
    step();
    chk("t33_gnt", int'(gnt_o[0]), 0);
    chk("t33_q", int'(q_o[0]), 0);
    chk("t33_valid", int'(valid_o[0]), 0);
    chk("t33_pulse", int'(pulse_o[0]), 0);

    // Wrap-around: 0 first, then 3.
    clear = 1'b0; req = 4'b1001;
    step();
    chk("t34_first", int'(gnt_o[0]), 4'b0001);
    for (int c = 0; c < 4; c++) step();
    chk("t34_second", int'(gnt_o[0]), 4'b1000);
    req = 4'b0000;
    for (int c = 0; c < 5; c++) step();

    // Quiet bus: nothing granted, nothing loaded.
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int c = 0; c < 10; c++) begin
      din_a[c % 4] = 4'($urandom_range(0, 15));
      step();
      chk("t35_idle_gnt1", int'(gnt_o[1]), 0);
      chk("t35_idle_pulse1", int'(pulse_o[1]), 0);
    end

    // Mixed traffic with occasional clears, checked by the model.
    for (int c = 0; c < 80; c++) begin
      req   = 4'($urandom_range(0, 15));
      clear = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < 4; i++) din_a[i] = 4'($urandom_range(0, 15));
      step();
    end
    clear = 1'b0; req = 4'b0000;
    for (int c = 0; c < 4; c++) step();

    @(posedge clk);
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
